apb_slave: RTL

APB_SLAVE -- requirements
Module: apb_slave

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb_slave_mem.sv | 63 ++++++
 rtl/apb_slave.sv | 122 ++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB byte-storage slave: bus widths, default
// sizing and the access FSM state encoding.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;

  // Only the low address bits index storage; the top bit belongs to the
  // master's slave-select decode.
  localparam int APB_IDX_W = APB_ADDR_W - 1;

  localparam int APB_DEFAULT_DEPTH       = 64;
  localparam int APB_DEFAULT_WAIT_CYCLES = 2;

  // Two-state access FSM.
  typedef logic [0:0] apb_state_t;
  localparam apb_state_t IDLE   = 1'b0;
  localparam apb_state_t ACCESS = 1'b1;

endpackage : apb_pkg

// File: rtl/apb_slave_mem.sv
// Byte storage for the APB slave: one register per location so the whole
// array can be cleared in a single reset cycle. Synchronous write, registered
// read, synchronous active-low clear.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = APB_DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [APB_IDX_W-1:0]  wr_addr,
  input  logic [APB_DATA_W-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  rd_zero,
  input  logic [APB_IDX_W-1:0]  rd_addr,
  output logic [APB_DATA_W-1:0] rd_data
);

  logic [DEPTH*APB_DATA_W-1:0] mem_flat;
  logic [APB_DATA_W-1:0]       rd_word;
  logic [APB_DATA_W-1:0]       rd_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cell
      logic [APB_DATA_W-1:0] cell_reg;

      // Each location clears on reset and captures data when addressed by a write.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cell_reg <= '0;
        end else if (wr_en && (wr_addr == APB_IDX_W'(gi))) begin
          cell_reg <= wr_data;
        end
      end

      assign mem_flat[gi*APB_DATA_W +: APB_DATA_W] = cell_reg;
    end
  endgenerate

  // Read mux; addresses beyond DEPTH select nothing and yield zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rd_addr == APB_IDX_W'(i)) begin
        rd_word = mem_flat[i*APB_DATA_W +: APB_DATA_W];
      end
    end
  end

  // Read data register: only a new read updates it, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_data_reg <= '0;
    end else if (rd_en) begin
      rd_data_reg <= rd_zero ? '0 : rd_word;
    end
  end

  assign rd_data = rd_data_reg;

endmodule : apb_slave_mem

// File: rtl/apb_slave.sv
// APB slave with DEPTH bytes of storage. Setup phase latches the request,
// access phase completes it once PREADY rises; out-of-range addresses answer
// with PSLVERR. Wait states are compiled in with the macro APB_SLAVE_WAIT_EN;
// without it every transfer completes in its first access cycle.
module apb_slave
  import apb_pkg::*;
#(
  parameter int DEPTH       = APB_DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = APB_DEFAULT_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [APB_ADDR_W-1:0] PADDR,
  input  logic [APB_DATA_W-1:0] PWDATA,
  output logic                  PREADY,
  output logic [APB_DATA_W-1:0] PRDATA,
  output logic                  PSLVERR
);

  // Elaboration-time parameter range checks.
  generate
    if (DEPTH < 1 || DEPTH > 256) begin : g_bad_depth
      $error("apb_slave: DEPTH must be within 1..256");
    end
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("apb_slave: WAIT_CYCLES must be within 0..15");
    end
  endgenerate

  // One bit wider than the index so DEPTH=256 is representable.
  localparam logic [APB_IDX_W:0] DEPTH_LIM = (APB_IDX_W + 1)'(DEPTH);

  apb_state_t            state_reg, state_next;
  logic [APB_IDX_W-1:0]  addr_reg;
  logic [APB_DATA_W-1:0] wdata_reg;
  logic                  write_reg;
  logic                  err_reg;

  logic                  setup;
  logic                  complete;
  logic                  addr_err;
  logic                  mem_wr_en;
  logic                  addr_msb_unused;

  // Bit 8 is consumed by the master's select decode.
  assign addr_msb_unused = PADDR[APB_ADDR_W-1];

  assign addr_err = {1'b0, PADDR[APB_IDX_W-1:0]} >= DEPTH_LIM;
  assign setup    = (state_reg == IDLE) && PSEL && !PENABLE;
  assign complete = (state_reg == ACCESS) && PREADY && PSEL && PENABLE;

`ifdef APB_SLAVE_WAIT_EN
  logic [3:0] cnt_reg;

  // Wait-state counter: loaded at setup, counts down while still selected.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (setup) begin
      cnt_reg <= 4'(WAIT_CYCLES);
    end else if ((state_reg == ACCESS) && PSEL && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 4'd1;
    end
  end

  assign PREADY = (state_reg == ACCESS) && (cnt_reg == '0);
`else
  assign PREADY = (state_reg == ACCESS);
`endif

  assign PSLVERR = PREADY && err_reg;

  // Next-state decode: enter ACCESS on setup, leave on completion or deselect.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (setup) state_next = ACCESS;
      ACCESS:  if (!PSEL || complete) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and request latches captured during the setup phase.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      write_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (setup) begin
        addr_reg  <= PADDR[APB_IDX_W-1:0];
        wdata_reg <= PWDATA;
        write_reg <= PWRITE;
        err_reg   <= addr_err;
      end
    end
  end

  // Only a completed, in-range write reaches storage.
  assign mem_wr_en = complete && write_reg && !err_reg;

  apb_slave_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr_en),
    .wr_addr (addr_reg),
    .wr_data (wdata_reg),
    .rd_en   (setup && !PWRITE),
    .rd_zero (addr_err),
    .rd_addr (PADDR[APB_IDX_W-1:0]),
    .rd_data (PRDATA)
  );

endmodule : apb_slave
